// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler: walks the MMIO counter select, captures each value and streams it out over valid/ready.
// Define PERF_SAMPLER_CLEAR_EN to follow each accepted word with a one-cycle MMIO_write clear of that counter.
module perf_counter_sampler #(
    parameter int NUM_CTRS = 11,
    parameter int SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  counter,
    output logic        MMIO_read,
    output logic        MMIO_write,
    input  logic [15:0] ctr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last
);
    localparam int WW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);
    localparam logic [3:0] IDX_LAST = 4'(NUM_CTRS - 1);
`ifdef PERF_SAMPLER_CLEAR_EN
    typedef enum logic [2:0] {IDLE, SELECT, SEND, CLEAR, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, SELECT, SEND, FIN} state_t;
`endif
    state_t        state;
    logic [3:0]    idx;
    logic [WW-1:0] wcnt;
    logic          adv;
`ifdef PERF_SAMPLER_CLEAR_EN
    logic clr_q;
    assign adv = state == CLEAR;
    assign MMIO_write = clr_q;
`else
    assign adv = state == SEND && out_ready;
    assign MMIO_write = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            counter   <= '0;
            MMIO_read <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
`ifdef PERF_SAMPLER_CLEAR_EN
            clr_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= SELECT;
                    idx       <= '0;
                    wcnt      <= '0;
                    counter   <= '0;
                    busy      <= 1'b1;
                    MMIO_read <= 1'b1;
                end
                SELECT: if (wcnt == WAIT_LAST) begin
                    out_data  <= ctr_data;
                    out_idx   <= idx;
                    out_last  <= idx == IDX_LAST;
                    out_valid <= 1'b1;
                    MMIO_read <= 1'b0;
                    state     <= SEND;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                SEND: if (out_ready) begin
                    out_valid <= 1'b0;
`ifdef PERF_SAMPLER_CLEAR_EN
                    state     <= CLEAR;
                    clr_q     <= 1'b1;
`endif
                end
`ifdef PERF_SAMPLER_CLEAR_EN
                CLEAR: clr_q <= 1'b0;
`endif
                FIN: begin
                    state   <= IDLE;
                    counter <= '0;
                end
                default: state <= IDLE;
            endcase
            // Shared tail of SEND (or CLEAR): finish the pass or select the next counter.
            if (adv) begin
                if (out_last) begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state     <= SELECT;
                    idx       <= idx + 4'd1;
                    counter   <= idx + 4'd1;
                    wcnt      <= '0;
                    MMIO_read <= 1'b1;
                end
            end
        end
    end
endmodule
